// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// default busy-cycle counts.
package md_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_t;

   function automatic logic md_is_multi(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational MDU datapath: (op, a, b) -> {hi, lo}, including the
// divide-by-zero and signed-overflow results.
module md_calc
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] quot_s, rem_s;
   logic        [31:0] quot_u, rem_u;
   logic               div_zero, div_ovf;

   assign a_sx   = {{32{a[31]}}, a};
   assign b_sx   = {{32{b[31]}}, b};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, a} * {32'd0, b};

   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   // Raw dividers are only trusted when neither corner case applies.
   assign quot_s = $signed(a) / $signed(b);
   assign rem_s  = $signed(a) % $signed(b);
   assign quot_u = a / b;
   assign rem_u  = a % b;

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         MD_MULT:  {hi, lo} = prod_s;
         MD_MULTU: {hi, lo} = prod_u;
         MD_DIV: begin
            if (div_zero) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               hi = 32'd0;
               lo = 32'h8000_0000;
            end else begin
               hi = rem_s;
               lo = quot_s;
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               hi = a;
               lo = 32'hFFFF_FFFF;
            end else begin
               hi = rem_u;
               lo = quot_u;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: runs MDU ops for a fixed number of
// cycles, owns HI/LO and requests pipeline stalls while busy.
module md_sched
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_V1,
   input  logic [31:0] E_V2,
   input  logic        D_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   md_state_t         state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [31:0]       pend_hi_reg, pend_lo_reg;
   logic [31:0]       hi_reg, lo_reg;
   logic [31:0]       calc_hi, calc_lo;
   logic              is_mul, start;

   md_calc u_calc (
      .op (E_md_op),
      .a  (E_V1),
      .b  (E_V2),
      .hi (calc_hi),
      .lo (calc_lo)
   );

   assign is_mul   = (E_md_op == MD_MULT) || (E_md_op == MD_MULTU);
   assign busy     = (state_reg == RUN);
   assign start    = md_is_multi(E_md_op) & ~Req & ~busy;
   assign md_stall = D_md & (busy | start);
   assign HI       = hi_reg;
   assign LO       = lo_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         pend_hi_reg <= 32'd0;
         pend_lo_reg <= 32'd0;
         hi_reg      <= 32'd0;
         lo_reg      <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg   <= RUN;
                  pend_hi_reg <= calc_hi;
                  pend_lo_reg <= calc_lo;
                  cnt_reg     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               end else if (!Req) begin
                  if (E_md_op == MD_MTHI) hi_reg <= E_V1;
                  if (E_md_op == MD_MTLO) lo_reg <= E_V1;
               end
            end
            RUN: begin
               // A flush arriving mid-run does not cancel: the op is already committed.
               if (cnt_reg == CNT_W'(1)) begin
                  hi_reg    <= pend_hi_reg;
                  lo_reg    <= pend_lo_reg;
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: table-driven MDU ops with a result
// scoreboard, plus hand sequences for reset, flush and MTHI/MTLO cases.
module tb_md_sched;
   import md_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Req = 1'b0;
   logic [2:0]  E_md_op = MD_NONE;
   logic [31:0] E_V1 = 32'd0;
   logic [31:0] E_V2 = 32'd0;
   logic        D_md = 1'b0;
   logic        busy, md_stall;
   logic [31:0] HI, LO;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   vec_t        vecs[11];

   always #5 clk = ~clk;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .Req      (Req),
      .E_md_op  (E_md_op),
      .E_V1     (E_V1),
      .E_V2     (E_V2),
      .D_md     (D_md),
      .busy     (busy),
      .md_stall (md_stall),
      .HI       (HI),
      .LO       (LO)
   );

   // A multi-cycle op must never be presented while the unit is busy.
   always @(negedge clk) begin
      if (reset && busy && md_is_multi(E_md_op)) begin
         n_bad++;
         $display("FAIL op_while_busy: got op %0d with busy=1, required no op", E_md_op);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          cyc;
      logic [63:0] e;
      tick();
      E_md_op = v.op; E_V1 = v.v1; E_V2 = v.v2; D_md = 1'b1; Req = 1'b0;
      @(negedge clk);
      check("start_stall", {31'd0, md_stall}, 32'd1);
      sb_q.push_back({v.hi, v.lo});
      tick();
      E_md_op = MD_NONE;
      cyc = 0;
      @(negedge clk);
      while (busy && cyc < 64) begin
         check("busy_stall", {31'd0, md_stall}, 32'd1);
         cyc++;
         @(negedge clk);
      end
      check("busy_cycles", cyc, v.n);
      check("stall_drop", {31'd0, md_stall}, 32'd0);
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check("hi", HI, e[63:32]);
         check("lo", LO, e[31:0]);
         m_hi = e[63:32];
         m_lo = e[31:0];
      end
      $display("vec %0d op=%0d v1=%h v2=%h -> HI=%h LO=%h busy_cycles=%0d", idx, v.op, v.v1, v.v2, HI, LO, cyc);
      D_md = 1'b0;
   endtask

   initial begin
      int cyc;
      vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
      vecs[2]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
      vecs[3]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10};
      vecs[4]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[5]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
      vecs[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
      vecs[7]  = '{MD_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 10};
      vecs[8]  = '{MD_DIVU,  32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 10};
      vecs[9]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         5};
      vecs[10] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, 10};

      // Reset held for one edge with a MULT presented.
      E_md_op = MD_MULT; E_V1 = 32'd3; E_V2 = 32'd3; D_md = 1'b1; reset = 1'b0;
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      E_md_op = MD_NONE; reset = 1'b1;
      @(negedge clk);
      check("rst_stall_idle", {31'd0, md_stall}, 32'd0);
      E_md_op = MD_MULT;
      #1;
      check("rst_stall_start", {31'd0, md_stall}, 32'd1);
      E_md_op = MD_NONE; D_md = 1'b0;
      $display("reset: busy=%0d HI=%h LO=%h", busy, HI, LO);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // Flushed DIV and MTHI must leave everything untouched.
      tick();
      E_md_op = MD_DIV; E_V1 = 32'd9; E_V2 = 32'd3; Req = 1'b1; D_md = 1'b1;
      @(negedge clk);
      check("req_div_stall", {31'd0, md_stall}, 32'd0);
      tick();
      check("req_div_busy", {31'd0, busy}, 32'd0);
      check("req_div_hi", HI, m_hi);
      check("req_div_lo", LO, m_lo);
      E_md_op = MD_MTHI; E_V1 = 32'd5;
      tick();
      check("req_mthi_hi", HI, m_hi);
      check("req_mthi_busy", {31'd0, busy}, 32'd0);
      $display("req discard: HI=%h LO=%h busy=%0d", HI, LO, busy);
      Req = 1'b0; E_md_op = MD_NONE; D_md = 1'b0;

      // Unflushed MTHI / MTLO take effect after one edge.
      E_md_op = MD_MTHI; E_V1 = 32'hCAFE_0001;
      tick();
      E_md_op = MD_MTLO; E_V1 = 32'hBEEF_0002;
      check("mthi_hi", HI, 32'hCAFE_0001);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      tick();
      E_md_op = MD_NONE;
      check("mtlo_lo", LO, 32'hBEEF_0002);
      $display("mthi/mtlo: HI=%h LO=%h", HI, LO);

      // Req raised mid-run does not cancel the op.
      E_md_op = MD_MULTU; E_V1 = 32'd6; E_V2 = 32'd7;
      tick();
      E_md_op = MD_NONE; Req = 1'b1;
      tick();
      tick();
      Req = 1'b0;
      cyc = 0;
      while (busy && cyc < 64) begin tick(); cyc++; end
      check("req_run_timeout", {31'd0, busy}, 32'd0);
      check("req_run_hi", HI, 32'd0);
      check("req_run_lo", LO, 32'd42);
      $display("req mid-run: HI=%h LO=%h", HI, LO);

      // Reset on the third busy cycle of a DIV, then MTLO.
      E_md_op = MD_DIV; E_V1 = 32'd100; E_V2 = 32'd7;
      tick();
      E_md_op = MD_NONE;
      tick();
      tick();
      check("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_hi", HI, 32'd0);
      check("mid_rst_lo", LO, 32'd0);
      E_md_op = MD_MTLO; E_V1 = 32'h1234;
      tick();
      E_md_op = MD_NONE;
      check("post_rst_mtlo", LO, 32'h1234);
      check("post_rst_hi", HI, 32'd0);
      tick();
      check("post_rst_idle", {31'd0, busy}, 32'd0);
      $display("reset mid-div: HI=%h LO=%h busy=%0d", HI, LO, busy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
